// File: rtl/waterfall_light_axil_slave.sv
// AXI4-Lite register file driving a rotating LED pattern engine.
// Four RW control words, one RO live LED word, OKAY responses only.
module waterfall_light_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_LEDS           = 8
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_LEDS-1:0]             led
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;

    logic [DW-1:0]       ctrl_q, period_q, pattern_q, scratch_q;
    logic                aw_latched, w_latched;
    logic [2:0]          aw_idx_q;
    logic [DW-1:0]       w_data_q;
    logic [SW-1:0]       w_strb_q;
    logic                awready_q, wready_q, bvalid_q;
    logic                arready_q, rvalid_q;
    logic [DW-1:0]       rdata_q;
    logic [31:0]         count_q;
    logic [NUM_LEDS-1:0] led_q;

    logic                wr_fire;
    logic [DW-1:0]       wr_old, wr_value, rd_word, led_word;
    logic [31:0]         period_eff;
    logic                step, pattern_wr, period_wr;
    logic                unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] data,
                                            input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old;
        for (int b = 0; b < SW; b++)
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        return res;
    endfunction

    function automatic logic [NUM_LEDS-1:0] rotate(input logic [NUM_LEDS-1:0] v,
                                                   input logic dir);
        logic [NUM_LEDS-1:0] r;
        for (int i = 0; i < NUM_LEDS; i++)
            r[i] = dir ? v[(i + 1) % NUM_LEDS]
                       : v[(i + NUM_LEDS - 1) % NUM_LEDS];
        return r;
    endfunction

    assign wr_fire    = aw_latched && w_latched && !bvalid_q;
    assign pattern_wr = wr_fire && (aw_idx_q == 3'd2);
    assign period_wr  = wr_fire && (aw_idx_q == 3'd1);
    assign period_eff = (period_q == '0) ? 32'd1 : period_q[31:0];
    assign step       = ctrl_q[0] && (count_q == period_eff - 32'd1);

    always_comb begin
        led_word = '0;
        led_word[NUM_LEDS-1:0] = led_q;
    end

    always_comb begin
        wr_old = '0;
        case (aw_idx_q)
            3'd0:    wr_old = ctrl_q;
            3'd1:    wr_old = period_q;
            3'd2:    wr_old = pattern_q;
            3'd3:    wr_old = scratch_q;
            default: wr_old = '0;
        endcase
        wr_value = merge(wr_old, w_data_q, w_strb_q);
    end

    always_comb begin
        rd_word = '0;
        case (S_AXI_ARADDR[4:2])
            3'd0:    rd_word = ctrl_q;
            3'd1:    rd_word = period_q;
            3'd2:    rd_word = pattern_q;
            3'd3:    rd_word = scratch_q;
            3'd4:    rd_word = led_word;
            default: rd_word = '0;
        endcase
    end

    // Write address/data are latched independently; the update fires once both are held.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            aw_latched <= 1'b0;
            w_latched  <= 1'b0;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            ctrl_q     <= '0;
            period_q   <= '0;
            pattern_q  <= '0;
            scratch_q  <= '0;
        end else begin
            awready_q <= S_AXI_AWVALID && !aw_latched && !bvalid_q && !awready_q;
            wready_q  <= S_AXI_WVALID && !w_latched && !bvalid_q && !wready_q;
            if (awready_q && S_AXI_AWVALID) begin
                aw_latched <= 1'b1;
                aw_idx_q   <= S_AXI_AWADDR[4:2];
            end
            if (wready_q && S_AXI_WVALID) begin
                w_latched <= 1'b1;
                w_data_q  <= S_AXI_WDATA;
                w_strb_q  <= S_AXI_WSTRB;
            end
            if (wr_fire) begin
                aw_latched <= 1'b0;
                w_latched  <= 1'b0;
                bvalid_q   <= 1'b1;
                case (aw_idx_q)
                    3'd0:    ctrl_q    <= wr_value;
                    3'd1:    period_q  <= wr_value;
                    3'd2:    pattern_q <= wr_value;
                    3'd3:    scratch_q <= wr_value;
                    default: ;
                endcase
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            arready_q <= S_AXI_ARVALID && !rvalid_q && !arready_q;
            if (arready_q && S_AXI_ARVALID) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // A pattern reload takes priority over a rotation landing on the same edge.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            led_q   <= '0;
            count_q <= '0;
        end else if (pattern_wr) begin
            led_q   <= wr_value[NUM_LEDS-1:0];
            count_q <= '0;
        end else begin
            if (step) led_q <= rotate(led_q, ctrl_q[1]);
            if (period_wr || !ctrl_q[0] || step) count_q <= '0;
            else count_q <= count_q + 32'd1;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign led           = led_q;

endmodule

// File: tb/tb_waterfall_light_axil_slave.sv
// Bench for waterfall_light_axil_slave: register access, strobes,
// channel ordering, LED rotation and asynchronous reset.
module tb_waterfall_light_axil_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;
    logic [7:0]  led;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  led_q[$];

    always #5 clk = ~clk;

    waterfall_light_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5),
        .NUM_LEDS(8)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr),
        .S_AXI_AWPROT(awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),
        .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp),
        .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr),
        .S_AXI_ARPROT(arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata),
        .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready),
        .led(led)
    );

    function automatic logic [7:0] rotl8(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    function automatic logic [7:0] rotr8(input logic [7:0] v);
        return {v[0], v[7:1]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        bit aw_hs, w_hs, done;
        done = 0;
        awaddr = addr; awvalid = 1; wdata = data; wstrb = strb; wvalid = 1;
        bready = 1;
        for (int c = 0; c < 50 && !done; c++) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) awvalid = 0;
            if (w_hs) wvalid = 0;
            if (bvalid) begin
                checks++;
                if (bresp !== 2'b00) begin
                    errors++;
                    $display("FAIL bresp addr=%h got=%b exp=00", addr, bresp);
                end
                tick();
                done = 1;
            end
        end
        bready = 0;
        if (!done) begin
            checks++; errors++;
            awvalid = 0; wvalid = 0;
            $display("FAIL write_timeout addr=%h got=no_bvalid exp=bvalid", addr);
        end
    endtask

    task automatic axi_read(input logic [4:0] addr, input logic [31:0] expected);
        bit ar_hs, done;
        logic [31:0] e;
        done = 0;
        exp_q.push_back(expected);
        araddr = addr; arvalid = 1; rready = 1;
        for (int c = 0; c < 50 && !done; c++) begin
            ar_hs = arvalid && arready;
            tick();
            if (ar_hs) arvalid = 0;
            if (rvalid) begin
                e = exp_q.pop_front();
                checks++;
                if (rdata !== e) begin
                    errors++;
                    $display("FAIL rdata addr=%h got=%h exp=%h", addr, rdata, e);
                end
                checks++;
                if (rresp !== 2'b00) begin
                    errors++;
                    $display("FAIL rresp addr=%h got=%b exp=00", addr, rresp);
                end
                tick();
                done = 1;
            end
        end
        rready = 0;
        if (!done) begin
            e = exp_q.pop_front();
            checks++; errors++;
            arvalid = 0;
            $display("FAIL read_timeout addr=%h got=no_rvalid exp=%h", addr, e);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0;
        wvalid = 0; bready = 0; araddr = '0; arprot = '0; arvalid = 0;
        rready = 0;
        repeat (3) tick();
        checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshake got=%b exp=00000",
                     {awready, wready, bvalid, arready, rvalid});
        end
        checks++;
        if (led !== 8'h00) begin
            errors++;
            $display("FAIL reset_led got=%h exp=00", led);
        end
        checks++;
        if (rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL reset_data got=%h/%b/%b exp=0/00/00", rdata, rresp, bresp);
        end
        rst_n = 1;
        repeat (2) tick();
        axi_read(5'h00, 32'h0);
        axi_read(5'h04, 32'h0);
    endtask

    task automatic test_regs();
        axi_write(5'h00, 32'h1, 4'hF);
        axi_write(5'h04, 32'h2, 4'hF);
        axi_write(5'h08, 32'h3, 4'hF);
        axi_write(5'h0C, 32'h4, 4'hF);
        axi_read(5'h00, 32'h1);
        axi_read(5'h04, 32'h2);
        axi_read(5'h08, 32'h3);
        axi_read(5'h0C, 32'h4);
        axi_write(5'h00, 32'hFFFF_FFFC, 4'hF);
        axi_write(5'h08, 32'h3, 4'hF);
        axi_read(5'h10, 32'h3);
        axi_read(5'h00, 32'hFFFF_FFFC);
        checks++;
        if (led !== 8'h03) begin
            errors++;
            $display("FAIL led_stopped got=%h exp=03", led);
        end
    endtask

    task automatic test_rotate();
        logic [7:0] v, prev, e;
        int since;
        bit first;
        axi_write(5'h08, 32'h1, 4'hF);
        axi_write(5'h04, 32'h4, 4'hF);
        v = 8'h01;
        for (int i = 0; i < 8; i++) begin
            v = rotl8(v);
            led_q.push_back(v);
        end
        axi_write(5'h00, 32'h1, 4'hF);
        prev = 8'h01; since = 0; first = 1;
        for (int c = 0; c < 80 && led_q.size() > 0; c++) begin
            tick();
            since++;
            if (led !== prev) begin
                e = led_q.pop_front();
                checks++;
                if (led !== e) begin
                    errors++;
                    $display("FAIL rotl_value got=%h exp=%h", led, e);
                end
                if (!first) begin
                    checks++;
                    if (since != 4) begin
                        errors++;
                        $display("FAIL rotl_interval got=%0d exp=4", since);
                    end
                end
                first = 0; prev = led; since = 0;
            end
        end
        if (led_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL rotl_timeout got=%0d_left exp=0_left", led_q.size());
            led_q.delete();
        end
        axi_write(5'h00, 32'h0, 4'hF);
        axi_write(5'h08, 32'h80, 4'hF);
        v = 8'h80;
        for (int i = 0; i < 3; i++) begin
            v = rotr8(v);
            led_q.push_back(v);
        end
        axi_write(5'h00, 32'h3, 4'hF);
        prev = 8'h80;
        for (int c = 0; c < 40 && led_q.size() > 0; c++) begin
            tick();
            if (led !== prev) begin
                e = led_q.pop_front();
                checks++;
                if (led !== e) begin
                    errors++;
                    $display("FAIL rotr_value got=%h exp=%h", led, e);
                end
                prev = led;
            end
        end
        if (led_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL rotr_timeout got=%0d_left exp=0_left", led_q.size());
            led_q.delete();
        end
        axi_write(5'h00, 32'h0, 4'hF);
    endtask

    task automatic test_w_before_aw();
        bit hs, got_b;
        awvalid = 0; bready = 0;
        wdata = 32'h5A5A_0001; wstrb = 4'hF; wvalid = 1;
        for (int c = 0; c < 3; c++) begin
            hs = wvalid && wready;
            tick();
            if (hs) wvalid = 0;
        end
        checks++;
        if (wvalid !== 1'b0) begin
            errors++; wvalid = 0;
            $display("FAIL w_accept got=not_accepted exp=accepted");
        end
        awaddr = 5'h0C; awvalid = 1; got_b = 0;
        for (int c = 0; c < 20 && !got_b; c++) begin
            hs = awvalid && awready;
            tick();
            if (hs) awvalid = 0;
            if (bvalid) got_b = 1;
        end
        awvalid = 0;
        checks++;
        if (!got_b) begin
            errors++;
            $display("FAIL b_arrive got=no_bvalid exp=bvalid");
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bvalid !== 1'b1) begin
                errors++;
                $display("FAIL b_hold cycle=%0d got=%b exp=1", c, bvalid);
            end
            tick();
        end
        bready = 1;
        tick();
        bready = 0;
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL b_release got=%b exp=0", bvalid);
        end
        repeat (4) begin
            tick();
            checks++;
            if (bvalid !== 1'b0) begin
                errors++;
                $display("FAIL b_single got=%b exp=0", bvalid);
            end
        end
        axi_read(5'h0C, 32'h5A5A_0001);
    endtask

    task automatic test_strobe();
        axi_write(5'h0C, 32'h1122_3344, 4'hF);
        axi_write(5'h0C, 32'hAABB_CCDD, 4'b0010);
        axi_read(5'h0C, 32'h1122_CC44);
        axi_write(5'h04, 32'hAABB_CCDD, 4'b1001);
        axi_read(5'h04, 32'hAA00_00DD);
    endtask

    task automatic test_unmapped_and_fast();
        logic [7:0] v;
        axi_read(5'h14, 32'h0);
        axi_write(5'h1C, 32'hDEAD_BEEF, 4'hF);
        axi_read(5'h1C, 32'h0);
        axi_write(5'h08, 32'h5A, 4'hF);
        axi_write(5'h10, 32'hFF, 4'hF);
        axi_read(5'h10, 32'h5A);
        axi_write(5'h04, 32'h0, 4'hF);
        axi_write(5'h00, 32'h1, 4'hF);
        v = 8'h5A;
        for (int c = 0; c < 10; c++) begin
            v = rotl8(v);
            checks++;
            if (led !== v) begin
                errors++;
                $display("FAIL fast_step cycle=%0d got=%h exp=%h", c, led, v);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_read();
        bit hs, got_r;
        araddr = 5'h08; arvalid = 1; rready = 0; got_r = 0;
        for (int c = 0; c < 20 && !got_r; c++) begin
            hs = arvalid && arready;
            tick();
            if (hs) arvalid = 0;
            if (rvalid) got_r = 1;
        end
        arvalid = 0;
        checks++;
        if (!got_r || rdata !== 32'h5A) begin
            errors++;
            $display("FAIL pre_reset_read got=%b/%h exp=1/0000005a", rvalid, rdata);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL async_rvalid got=%b exp=0", rvalid);
        end
        checks++;
        if (led !== 8'h00) begin
            errors++;
            $display("FAIL async_led got=%h exp=00", led);
        end
        tick();
        tick();
        rst_n = 1;
        tick();
        axi_read(5'h00, 32'h0);
        axi_read(5'h08, 32'h0);
        axi_read(5'h0C, 32'h0);
        checks++;
        if (led !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_led got=%h exp=00", led);
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_rotate();
        test_w_before_aw();
        test_strobe();
        test_unmapped_and_fast();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
